// File: rtl/intdiv_seq_ctrl_if.sv
// Host-side handshake and result bus of the sequential SD2 integer divider.
interface intdiv_seq_ctrl_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic [2*N-1:0] q_sd2;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder, q_sd2
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, quotient, remainder, q_sd2
  );
endinterface

// File: rtl/intdiv_seq_ctrl.sv
// Non-restoring unsigned N-bit divider controller: one SD2 digit per cycle,
// then LSB-first SD2-to-binary conversion through one subtract cell.
module intdiv_seq_ctrl #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  intdiv_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] POS1_1 = 2'b01;
  localparam logic [1:0] NEG1   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ITER, S_CONV, S_FIX, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N-1:0]      r_d, r_x, r_quot, r_rem;
  logic signed [N:0] r_r;
  logic [CW-1:0]     r_cnt;
  logic              r_neg, r_borrow, r_busy, r_done, r_div_zero;
  logic [2*N-1:0]    r_qsd2;

  logic              w_accept, w_zero, w_last;
  logic signed [N:0] w_r_nxt;
  logic [1:0]        w_digit, w_cur_dig, w_cell;

  // 2R + x -/+ D; the true result always fits N+1 bits, so wrapping
  // arithmetic on {R[N-1:0], x} is exact.
  function automatic logic signed [N:0] nr_step(input logic signed [N:0] r,
                                                input logic xb,
                                                input logic [N-1:0] d);
    if (r[N])
      return $signed({r[N-1:0], xb}) + $signed({1'b0, d});
    else
      return $signed({r[N-1:0], xb}) - $signed({1'b0, d});
  endfunction

  // SD2 subtract cell: {tr, sum} such that sum - 2*tr = digit - min.
  function automatic logic [1:0] sd2_sub(input logic [1:0] sub, input logic min);
    case (sub)
      2'b00:   return {min, min};
      NEG1:    return {1'b1, ~min};
      default: return {1'b0, ~min};
    endcase
  endfunction

  function automatic logic [N-1:0] fix_rem(input logic [N-1:0] r, input logic neg,
                                           input logic [N-1:0] d);
    return neg ? (r + d) : r;
  endfunction

  assign w_zero    = (bus.divisor == '0);
  assign w_last    = (r_cnt == CW'(N - 1));
  assign w_digit   = r_r[N] ? NEG1 : POS1_1;
  assign w_r_nxt   = nr_step(r_r, r_x[N-1], r_d);
  assign w_cur_dig = r_qsd2[{r_cnt, 1'b0} +: 2];
  assign w_cell    = sd2_sub(w_cur_dig, r_borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A start seen while the done pulse is still showing is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start && !r_done) begin
        w_accept    = 1'b1;
        w_state_nxt = w_zero ? S_DONE : S_ITER;
      end
      S_ITER:  if (w_last) w_state_nxt = S_CONV;
      S_CONV:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d        <= '0;
      r_x        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_borrow   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_qsd2     <= '0;
    end else begin
      r_busy <= (r_state == S_ITER) || (r_state == S_CONV) || (r_state == S_FIX);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_d        <= bus.divisor;
          r_x        <= bus.dividend;
          r_r        <= '0;
          r_cnt      <= '0;
          r_neg      <= 1'b0;
          r_borrow   <= 1'b0;
          r_div_zero <= w_zero;
          r_qsd2     <= '0;
          r_quot     <= w_zero ? '1 : '0;
          r_rem      <= w_zero ? bus.dividend : '0;
        end
        // Digits shift in at the bottom, so cycle k ends up at position N-1-k.
        S_ITER: begin
          r_r    <= w_r_nxt;
          r_x    <= {r_x[N-2:0], 1'b0};
          r_qsd2 <= {r_qsd2[2*N-3:0], w_digit};
          r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) begin
            r_neg    <= w_r_nxt[N];
            r_borrow <= w_r_nxt[N];
          end
        end
        S_CONV: begin
          r_quot[r_cnt] <= w_cell[0];
          r_borrow      <= w_cell[1];
          r_cnt         <= w_last ? '0 : r_cnt + CW'(1);
        end
        S_FIX:   r_rem <= fix_rem(r_r[N-1:0], r_neg, r_d);
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.div_zero  = r_div_zero;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.q_sd2     = r_qsd2;
endmodule

// File: tb/tb_intdiv_seq_ctrl.sv
// Bench for intdiv_seq_ctrl: directed literal cases plus a free-running random
// start/operand stream checked cycle by cycle against an arithmetic model.
module tb_intdiv_seq_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;

  intdiv_seq_ctrl_if #(.N(N)) bus();

  intdiv_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: transaction-level timing (edge countdown) plus plain / and %.
  bit m_active = 1'b0, m_zero = 1'b1, m_done = 1'b0, m_busy = 1'b0;
  bit m_dz = 1'b0, m_valid = 1'b1;
  int m_left = 0;
  int m_q = 0, m_r = 0;
  int sv;
  bit sok;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_active = 1'b0; m_zero = 1'b1; m_done = 1'b0; m_busy = 1'b0;
        m_dz = 1'b0; m_valid = 1'b1; m_q = 0; m_r = 0; m_left = 0;
      end else if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0; m_done = 1'b1; m_busy = 1'b0; m_valid = 1'b1;
        end else begin
          m_busy = !m_zero;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (bus.start) begin
        m_active = 1'b1;
        m_zero   = (bus.divisor == 0);
        m_left   = m_zero ? 1 : 2 * N + 2;
        m_busy   = 1'b0;
        m_valid  = 1'b0;
        m_dz     = m_zero;
        if (m_zero) begin
          m_q = (1 << N) - 1;
          m_r = int'(bus.dividend);
        end else begin
          m_q = int'(bus.dividend) / int'(bus.divisor);
          m_r = int'(bus.dividend) % int'(bus.divisor);
        end
      end
      #1;
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("div_zero", bus.div_zero, m_dz);
      if (m_valid) begin
        chk("quotient", bus.quotient, m_q);
        chk("remainder", bus.remainder, m_r);
        if (m_zero) begin
          chk("q_sd2_clear", bus.q_sd2, 0);
        end else begin
          sv = 0;
          sok = 1'b1;
          for (int i = 0; i < N; i++) begin
            case (bus.q_sd2[2*i +: 2])
              2'b01:   sv += (1 << i);
              2'b11:   sv -= (1 << i);
              default: sok = 1'b0;
            endcase
          end
          chk("q_sd2_digits", sok, 1);
          // All-nonzero SD2 digits sum to an odd value: Q itself or Q+1.
          chk("q_sd2_value", sv, m_q | 1);
        end
      end
    end
  end

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] d, input bit inject,
                        output int lat, output int busy_cnt, output int done_cnt);
    int  k;
    bit  seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = x;
    bus.divisor  = d;
    lat = 0; busy_cnt = 0; done_cnt = 0; seen = 1'b0; k = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (inject && (k == 4 || k == 9)) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50 + 8'(k);
        bus.divisor  = 8'd3;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        seen = 1'b1;
        lat  = k - 1;
      end
    end
    chk("op_completes", seen, 1);
    @(negedge clk);
    if (bus.done) done_cnt++;
  endtask

  int lat, bc, dc;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_q_sd2", bus.q_sd2, 0);
    rst_n = 1'b1;

    run_op(8'd100, 8'd7, 1'b0, lat, bc, dc);
    chk("100/7_latency", lat, 18);
    chk("100/7_q", bus.quotient, 14);
    chk("100/7_r", bus.remainder, 2);
    chk("100/7_dz", bus.div_zero, 0);

    run_op(8'd255, 8'd1, 1'b0, lat, bc, dc);
    chk("255/1_q", bus.quotient, 255);
    chk("255/1_r", bus.remainder, 0);

    run_op(8'd5, 8'd9, 1'b0, lat, bc, dc);
    chk("5/9_q", bus.quotient, 0);
    chk("5/9_r", bus.remainder, 5);

    run_op(8'd200, 8'd0, 1'b0, lat, bc, dc);
    chk("200/0_latency", lat, 1);
    chk("200/0_dz", bus.div_zero, 1);
    chk("200/0_q", bus.quotient, 255);
    chk("200/0_r", bus.remainder, 200);

    run_op(8'd9, 8'd3, 1'b0, lat, bc, dc);
    chk("9/3_dz", bus.div_zero, 0);
    chk("9/3_q", bus.quotient, 3);
    chk("9/3_r", bus.remainder, 0);

    run_op(8'd100, 8'd7, 1'b1, lat, bc, dc);
    chk("inject_q", bus.quotient, 14);
    chk("inject_r", bus.remainder, 2);
    chk("inject_busy_cycles", bc, 17);
    chk("inject_done_pulses", dc, 1);

    // Asynchronous abort in the middle of the iteration phase.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_q_sd2", bus.q_sd2, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("post_abort_no_done", bus.done, 0);
    end

    run_op(8'd17, 8'd5, 1'b0, lat, bc, dc);
    chk("17/5_q", bus.quotient, 3);
    chk("17/5_r", bus.remainder, 2);

    // Free-running random requests; acceptance rules are left to the model.
    repeat (40000) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.dividend = N'($urandom);
      case ($urandom_range(0, 15))
        0:       bus.divisor = '0;
        1, 2:    bus.divisor = N'($urandom_range(1, 4));
        3:       bus.divisor = '1;
        default: bus.divisor = N'($urandom);
      endcase
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * N + 6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
